// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, FSM states and opcode helpers shared by the ALU sequencer
package alu_ctrl_pkg;
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOT   = 4'd4;
    localparam logic [3:0] OP_NEG   = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_SHRA  = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_ROR   = 4'd11;
    localparam logic [3:0] OP_ROL   = 4'd12;
    localparam logic [3:0] OP_INCPC = 4'd13;
    localparam int NUM_OPS = 14;
    typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WAIT, DONE} state_t;
    function automatic logic is_muldiv(input logic [3:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction
    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_INCPC;
    endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: registered opcode plus active flag to one-hot ALU control lines
import alu_ctrl_pkg::*;
module alu_op_decode (
    input  logic [3:0]         op_i,
    input  logic               active_i,
    output logic [NUM_OPS-1:0] onehot_o,
    output logic               legal_o
);
    // one line per opcode, only while the sequencer is driving the ALU
    always_comb begin
        legal_o  = is_legal(op_i);
        onehot_o = (active_i && legal_o) ? {{(NUM_OPS-1){1'b0}}, 1'b1} << op_i : '0;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences Y load, ALU op and result capture for one request at a time
import alu_ctrl_pkg::*;
module alu_sequencer #(
    parameter int unsigned MULDIV_WAIT = 3
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] bus_out,
    output logic        y_in,
    output logic        op_add,
    output logic        op_sub,
    output logic        op_mul,
    output logic        op_div,
    output logic        op_and,
    output logic        op_or,
    output logic        op_not,
    output logic        op_neg,
    output logic        op_shr,
    output logic        op_shra,
    output logic        op_shl,
    output logic        op_ror,
    output logic        op_rol,
    output logic        op_incpc,
    input  logic [63:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err
);
    state_t state_q, state_d;
    logic [3:0] op_q, op_d, cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic err_q, err_d, cap, active, legal;
    logic [NUM_OPS-1:0] ops;

    assign active    = state_q == EXEC || state_q == WAIT;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == DONE;
    assign y_in      = state_q == LOAD_Y;
    assign bus_out   = y_in ? a_q : active ? b_q : '0;
    assign rsp_hi    = hi_q;
    assign rsp_lo    = lo_q;
    assign rsp_err   = err_q;
    assign {op_incpc, op_rol, op_ror, op_shl, op_shra, op_shr, op_div, op_mul,
            op_neg, op_not, op_or, op_and, op_sub, op_add} = ops;

    alu_op_decode u_dec (
        .op_i     (op_q),
        .active_i (active),
        .onehot_o (ops),
        .legal_o  (legal)
    );

    // state, operand, counter and result registers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // next-state: accept, Y load, execute, multicycle hold, respond
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d = req_op;
                a_d  = req_a;
                b_d  = req_b;
                if (!is_legal(req_op) || (req_op == OP_DIV && req_b == '0)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    hi_d    = '0;
                    lo_d    = '0;
                end else begin
                    state_d = req_op == OP_INCPC ? EXEC : LOAD_Y;
                end
            end
            LOAD_Y: state_d = EXEC;
            EXEC: if (is_muldiv(op_q) && MULDIV_WAIT != 0) begin
                cnt_d   = 4'(MULDIV_WAIT - 1);
                state_d = WAIT;
            end else begin
                cap = 1'b1;
            end
            WAIT: begin
                cap   = cnt_q == '0;
                cnt_d = cap ? cnt_q : cnt_q - 4'd1;
            end
            DONE: if (rsp_ready) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            state_d = DONE;
            hi_d    = alu_result[63:32];
            lo_d    = alu_result[31:0];
            err_d   = !legal;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with an ALU/Y environment model and a reference result model
module tb_alu_sequencer;
    localparam int W = 3;

    logic clock, clear_n, req_valid, req_ready, y_in, rsp_valid, rsp_ready, rsp_err;
    logic [3:0] req_op;
    logic [31:0] req_a, req_b, bus_out, rsp_hi, rsp_lo, y_reg;
    logic [63:0] alu_result;
    logic op_add, op_sub, op_mul, op_div, op_and, op_or, op_not, op_neg;
    logic op_shr, op_shra, op_shl, op_ror, op_rol, op_incpc;
    logic [13:0] ops;

    typedef struct {
        logic [31:0] hi, lo;
        logic err;
        int lat, ny, nop, t_acc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0, miscompares = 0, cyc = 0, hs_cyc = 0, ny = 0, nop = 0;
    bit seen = 0, bp_hold = 0;

    alu_sequencer #(.MULDIV_WAIT(W)) dut (
        .clock(clock), .clear_n(clear_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .bus_out(bus_out), .y_in(y_in),
        .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul), .op_div(op_div),
        .op_and(op_and), .op_or(op_or), .op_not(op_not), .op_neg(op_neg),
        .op_shr(op_shr), .op_shra(op_shra), .op_shl(op_shl), .op_ror(op_ror),
        .op_rol(op_rol), .op_incpc(op_incpc), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
    );

    assign ops = {op_incpc, op_rol, op_ror, op_shl, op_shra, op_shr, op_div, op_mul,
                  op_neg, op_not, op_or, op_and, op_sub, op_add};

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Y register of the datapath
    always @(posedge clock) if (y_in) y_reg <= bus_out;

    // ALU behaviour as seen through the Y register and the bus
    always_comb begin
        logic [4:0] s;
        logic signed [31:0] sy, sbus;
        s = bus_out[4:0];
        sy = y_reg;
        sbus = bus_out;
        alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        if (op_add) alu_result = {32'b0, y_reg + bus_out};
        else if (op_sub) alu_result = {32'b0, y_reg - bus_out};
        else if (op_and) alu_result = {32'b0, y_reg & bus_out};
        else if (op_or) alu_result = {32'b0, y_reg | bus_out};
        else if (op_not) alu_result = {32'b0, ~bus_out};
        else if (op_neg) alu_result = {32'b0, 32'd0 - bus_out};
        else if (op_mul) alu_result = $signed({{32{y_reg[31]}}, y_reg}) * $signed({{32{bus_out[31]}}, bus_out});
        else if (op_div) alu_result = bus_out == 0 ? 64'h0 : {32'(sy % sbus), 32'(sy / sbus)};
        else if (op_shr) alu_result = {32'b0, y_reg >> s};
        else if (op_shra) alu_result = {32'b0, 32'(sy >>> s)};
        else if (op_shl) alu_result = {32'b0, y_reg << s};
        else if (op_ror) alu_result = {32'b0, (y_reg >> s) | (y_reg << (32 - int'(s)))};
        else if (op_rol) alu_result = {32'b0, (y_reg << s) | (y_reg >> (32 - int'(s)))};
        else if (op_incpc) alu_result = {32'b0, bus_out + 32'd1};
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        logic [63:0] r, rr;
        logic signed [63:0] sa, sbb;
        logic signed [31:0] qa, qb;
        int s;
        s = int'(b[4:0]);
        sa = $signed(a);
        sbb = $signed(b);
        qa = a;
        qb = b;
        rr = {a, a};
        m.err = op > 13 || (op == 7 && b == 0);
        m.lat = m.err ? 1 : op == 13 ? 2 : (op == 6 || op == 7) ? 3 + W : 3;
        m.ny = (m.err || op == 13) ? 0 : 1;
        m.nop = m.err ? 0 : (op == 6 || op == 7) ? 1 + W : 1;
        r = 0;
        case (op)
            0: r[31:0] = a + b;
            1: r[31:0] = a - b;
            2: r[31:0] = a & b;
            3: r[31:0] = a | b;
            4: r[31:0] = ~b;
            5: r[31:0] = -b;
            6: r = sa * sbb;
            7: if (b != 0) r = {32'(qa % qb), 32'(qa / qb)};
            8: r[31:0] = a >> s;
            9: r[31:0] = 32'(qa >>> s);
            10: r[31:0] = a << s;
            11: r[31:0] = 32'(rr >> s);
            12: r[31:0] = 32'((rr << s) >> 32);
            13: r[31:0] = b + 1;
            default: r = 0;
        endcase
        m.hi = r[63:32];
        m.lo = r[31:0];
        m.t_acc = 0;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int tacc);
        exp_t e;
        int n;
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 300);
        tacc = cyc;
        if (!req_ready) begin
            check("accept_timeout", req_ready, 1);
        end else begin
            e = model(op, a, b);
            e.t_acc = cyc;
            sb.push_back(e);
        end
        @(posedge clock);
        #1 req_valid = 0;
        req_op = 4'($urandom);
        req_a = $urandom;
        req_b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hi", rsp_hi, 0);
        check("rst_rsp_lo", rsp_lo, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_y_in", y_in, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_ops", ops, 0);
    endtask

    // response monitor and scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (!clear_n) begin
            seen = 0;
            ny = 0;
            nop = 0;
        end else begin
            check("onehot", 64'($countones(ops) <= 1), 1);
            if (y_in) ny++;
            if (ops != 0) nop++;
            if (rsp_valid) begin
                check("req_ready_in_done", req_ready, 0);
                if (sb.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        check("latency", 64'(cyc - e.t_acc), 64'(e.lat));
                        check("y_in_cycles", 64'(ny), 64'(e.ny));
                        check("op_cycles", 64'(nop), 64'(e.nop));
                        seen = 1;
                    end
                    check("rsp_hi", rsp_hi, e.hi);
                    check("rsp_lo", rsp_lo, e.lo);
                    check("rsp_err", rsp_err, e.err);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                        ny = 0;
                        nop = 0;
                        hs_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        rsp_ready = 0;
        @(posedge clock);
        forever begin
            #1 rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
            @(posedge clock);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n;
        logic [3:0] op;
        logic [31:0] a, b;
        clear_n = 0;
        req_valid = 0;
        req_op = 0;
        req_a = 0;
        req_b = 0;
        #3 check_reset_values();
        #9 clear_n = 1;
        @(posedge clock);
        #1;
        issue(4'd0, 32'd5, 32'd7, t);
        drain();
        issue(4'd6, 32'hFFFF_FFFF, 32'd2, t);
        drain();
        issue(4'd7, 32'd1234, 32'd0, t);
        drain();
        issue(4'd15, 32'd9, 32'd3, t);
        drain();
        issue(4'd13, 32'd77, 32'h0000_00FF, t);
        drain();

        bp_hold = 1;
        issue(4'd1, 32'd100, 32'd58, t);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("bp_rsp_valid_seen", rsp_valid, 1);
        @(posedge clock);
        #1 req_op = 4'd2;
        req_a = 32'hF0F0_1234;
        req_b = 32'h0FF0_FFFF;
        req_valid = 1;
        repeat (5) begin
            @(negedge clock);
            check("bp_req_ready", req_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
        end
        bp_hold = 0;
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, t);
        check("accept_after_handshake", 64'(t - hs_cyc), 1);
        drain();

        issue(4'd7, 32'd100, 32'd7, t);
        @(posedge clock);
        @(posedge clock);
        #3 check("in_wait_op_div", op_div, 1);
        clear_n = 0;
        sb.delete();
        #1 check_reset_values();
        @(posedge clock);
        @(posedge clock);
        #2 clear_n = 1;
        repeat (6) begin
            @(negedge clock);
            check("no_rsp_after_reset", rsp_valid, 0);
        end
        @(posedge clock);
        #1;
        issue(4'd0, 32'd40, 32'd2, t);
        drain();

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom);
            a = $urandom;
            b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
            if (op == 4'd7 && $urandom_range(0, 3) == 0) b = 0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
            issue(op, a, b, t);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the Mini SRC ALU for one requester at a time. It accepts an opcode and two 32-bit operands over a valid/ready handshake. It then drives the operand bus, the Y-register load and the one-hot ALU operation lines, and captures the 64-bit ALU result into its own HI/LO result registers. MUL and DIV are treated as multicycle paths and are held stable for a programmable number of extra cycles. It sits between the control unit and the ALU/Y datapath.

## Interface
- MULDIV_WAIT, 3, extra cycles that MUL/DIV controls are held before capture (0..15)
- clock  in  1  rising-edge system clock
- clear_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; equals (state == IDLE)
- req_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 NEG, 6 MUL, 7 DIV, 8 SHR, 9 SHRA, 10 SHL, 11 ROR, 12 ROL, 13 INCPC; 14–15 illegal
- req_a, req_b  in  32 each  operands (A goes to Y; B is the second operand or shift count)
- bus_out  out  32  operand driven toward the ALU B input / Y
- y_in  out  1  Y-register load strobe
- op_add, op_sub, op_mul, op_div, op_and, op_or, op_not, op_neg, op_shr, op_shra, op_shl, op_ror, op_rol, op_incpc  out  1 each  one-hot ALU controls
- alu_result  in  64  ALU result
- rsp_valid  out  1  result available
- rsp_ready  in  1  requester consumes the result
- rsp_hi, rsp_lo  out  32 each  captured result[63:32] and result[31:0]
- rsp_err  out  1  illegal opcode or divide by zero

## Operation
- States: IDLE, LOAD_Y, EXEC, WAIT, DONE.
- **IDLE**
  - On req_valid && req_ready: register op, a and b.
  - Illegal op, or DIV with req_b == 0 → DONE with err=1 and HI/LO cleared.
  - INCPC → EXEC (no Y load).
  - Otherwise → LOAD_Y.
- **LOAD_Y**
  - Drive bus_out = A and y_in = 1.
  - Op lines all 0.
  - → EXEC.
- **EXEC**
  - Drive bus_out = B and assert exactly one op line.
  - Non-MUL/DIV: capture alu_result into HI/LO at this edge, → DONE.
  - MUL/DIV:
    - MULDIV_WAIT = 0: capture at this edge, → DONE.
    - Otherwise: load the counter with MULDIV_WAIT−1, → WAIT.
- **WAIT**
  - Hold bus_out = B and the op line.
  - Counter == 0: capture, → DONE.
  - Otherwise: decrement.
- **DONE**
  - rsp_valid = 1; HI/LO/err held stable.
  - On rsp_ready → IDLE and clear err.
- Outside the active states, bus_out = 0, y_in = 0 and all op lines = 0.
- At most one op line is high in any cycle.
- Captured values are the raw ALU output. Single-cycle ops arrive with HI already 0 from the ALU.

## Timing
- Reset (async, clear_n low):
  - state IDLE, counter 0
  - rsp_hi/rsp_lo 0, rsp_err 0, rsp_valid 0
  - all op lines 0, y_in 0, bus_out 0
  - req_ready 1 immediately
- Reset mid-operation: the transaction is discarded and no response is issued.
- Latency from the accept edge to rsp_valid high:
  - 3 cycles for ALU ops
  - 2 cycles for INCPC
  - 3 + MULDIV_WAIT cycles for MUL/DIV
  - 1 cycle for error
- rsp_valid && rsp_ready in DONE: IDLE on the next cycle. A new request can be accepted no earlier than 1 cycle after the response handshake (no overlap).
- rsp_ready while not in DONE is ignored.
- req_valid while busy is not accepted; the request stays pending.
- All outputs are registered or pure decodes of state/registered fields. No combinational path runs from req_* to bus/op outputs.

## Structure
- Shared package alu_ctrl_pkg:
  - opcode localparams OP_ADD..OP_INCPC
  - state encoding
  - the `is_muldiv` function
- Sub-module alu_op_decode: 4-bit registered opcode plus an active flag → 14 one-hot op lines plus `legal`. Purely combinational.
- Top level holds the FSM, operand/result registers and the wait counter.

## Test plan
- ADD, a=5, b=7, ALU model returns 12:
  - y_in with bus_out=5 one cycle after accept, then op_add with bus_out=7
  - rsp_lo=12, rsp_hi=0, err=0, rsp_valid 3 cycles after accept
- MUL, MULDIV_WAIT=3, a=0xFFFF_FFFF, b=2:
  - op_mul held 4 consecutive cycles
  - rsp_hi=0xFFFF_FFFF, rsp_lo=0xFFFF_FFFE (signed −2) at latency 6
- DIV, b=0: no y_in and no op line pulse; rsp_valid after 1 cycle with err=1 and HI/LO=0. Opcode 15 gives the same result.
- INCPC, b=0x0000_00FF: no y_in; op_incpc for one cycle; rsp_lo=0x100 at latency 2.
- Backpressure:
  - hold rsp_ready=0 for 5 cycles: response stable, req_ready=0, a second req_valid is not accepted
  - release: the second request is accepted one cycle after the response handshake
- clear_n pulsed low during WAIT of a DIV:
  - all outputs reach reset values asynchronously, and no rsp_valid follows
  - next ADD completes normally
